lfsr_encrypt_stage: RTL and testbench

Upstream encryption stage for the lab 5 LFSR cipher. On `start` it reads a plaintext message from data memory addresses 0 and up. It prepends a preamble of `_` (0x5f) characters and pads with spaces. Each byte is XORed with the running state of a selected 6-bit maximal-length LFSR, and the 64-byte ciphertext is written to addresses 64–127. That region is what the downstream decryptor reads, using the preamble to identify the tap pattern and seed.

---
 rtl/lfsr_pkg.sv | 39 +++
 rtl/lfsr6b.sv | 43 ++++
 rtl/lfsr_encrypt_stage.sv | 161 ++++++++++++++++
 tb/tb_lfsr_encrypt_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: constants, state encoding and LFSR step function for the lab 5
// LFSR cipher. Shared by the encryption stage and the downstream decryptor.
//   LFSR_PTRN     : tap table of the six maximal-length 6-bit LFSRs
//   PREAMBLE_CHAR : byte prepended to every message ('_')
//   PAD_CHAR      : byte used to fill the ciphertext after the message (' ')
//   enc_state_t   : encryptor FSM states
package lfsr_pkg;

  localparam int unsigned LFSR_W   = 6;
  localparam int unsigned NUM_PTRN = 6;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [LFSR_W-1:0] LFSR_PTRN [NUM_PTRN] = '{
    6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
  };

  localparam logic [BYTE_W-1:0] PREAMBLE_CHAR = 8'h5f;
  localparam logic [BYTE_W-1:0] PAD_CHAR      = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } enc_state_t;

  // One LFSR step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur,
                                                  input logic [LFSR_W-1:0] taps);
    return {cur[LFSR_W-2:0], ^(cur & taps)};
  endfunction

  // Out-of-range tap selects fall back to pattern 0.
  function automatic logic [SEL_W-1:0] ptrn_index(input logic [SEL_W-1:0] sel);
    return (sel >= SEL_W'(NUM_PTRN)) ? '0 : sel;
  endfunction

endpackage

// File: rtl/lfsr6b.sv
// lfsr6b: 6-bit Fibonacci-style LFSR with runtime taps.
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   en         : advance one step this cycle
//   init       : load `start` into the state (wins over en)
//   taps       : feedback tap mask
//   start      : value loaded on init
//   state      : current LFSR state
module lfsr6b
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              init,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] start,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next-state: load, step or hold.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = start;
    end else if (en) begin
      state_d = lfsr_next(state_q, taps);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_encrypt_stage.sv
// lfsr_encrypt_stage: reads a plaintext message from memory, frames it with a
// '_' preamble and ' ' padding, XORs every byte with a 6-bit LFSR keystream
// and writes OUT_LEN ciphertext bytes starting at OUT_BASE.
//   clk, init_n : clock, asynchronous active-low reset
//   start       : begin a run (sampled in IDLE and DONE)
//   tap_sel     : tap pattern index 0-5 (6, 7 map to 0)
//   seed        : LFSR start state (0 maps to 1)
//   pre_len     : preamble length 1-15 (0 maps to 1)
//   msg_len     : plaintext length in bytes
//   raddr       : plaintext read address, data_out is the combinational read data
//   wr_en, waddr, data_in : ciphertext write port
//   busy        : high in LOAD and RUN
//   done        : high in DONE
// Write-port and read-address outputs are decoded from registered state and
// are forced to 0 outside RUN.
module lfsr_encrypt_stage
  import lfsr_pkg::*;
#(
  parameter int unsigned OUT_BASE = 64,
  parameter int unsigned OUT_LEN  = 64
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  tap_sel,
  input  logic [LFSR_W-1:0] seed,
  input  logic [3:0]        pre_len,
  input  logic [6:0]        msg_len,
  output logic [BYTE_W-1:0] raddr,
  input  logic [BYTE_W-1:0] data_out,
  output logic              wr_en,
  output logic [BYTE_W-1:0] waddr,
  output logic [BYTE_W-1:0] data_in,
  output logic              busy,
  output logic              done
);

  localparam int unsigned K_W   = 8;
  localparam int unsigned CMP_W = K_W + 1;
  localparam logic [K_W-1:0]    K_LAST    = K_W'(OUT_LEN - 1);
  localparam logic [BYTE_W-1:0] BASE_ADDR = BYTE_W'(OUT_BASE);

  enc_state_t state_q, state_d;

  logic [K_W-1:0]    k_q, k_d;
  logic [LFSR_W-1:0] taps_q, taps_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [3:0]        pre_q, pre_d;
  logic [6:0]        msg_q, msg_d;

  logic              lfsr_en;
  logic              lfsr_init;
  logic [LFSR_W-1:0] lfsr_state;

  logic [CMP_W-1:0]  k_ext;
  logic [CMP_W-1:0]  pre_end;
  logic [CMP_W-1:0]  msg_end;
  logic [BYTE_W-1:0] ptxt;
  logic [BYTE_W-1:0] rd_addr;
  logic              in_run;

  // Single keystream generator; taps come from the registered pattern mux.
  lfsr6b u_lfsr (
    .clk   (clk),
    .rst_n (init_n),
    .en    (lfsr_en),
    .init  (lfsr_init),
    .taps  (taps_q),
    .start (seed_q),
    .state (lfsr_state)
  );

  // Next-state and control. Run parameters are captured on the same edge that
  // accepts start, since inputs are only guaranteed valid in IDLE/DONE; LOAD
  // then seeds the LFSR from the captured value.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    taps_d    = taps_q;
    seed_d    = seed_q;
    pre_d     = pre_q;
    msg_d     = msg_q;
    lfsr_en   = 1'b0;
    lfsr_init = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          taps_d  = LFSR_PTRN[ptrn_index(tap_sel)];
          seed_d  = (seed == '0) ? LFSR_W'(1) : seed;
          pre_d   = (pre_len == 4'd0) ? 4'd1 : pre_len;
          msg_d   = msg_len;
        end
      end
      LOAD: begin
        lfsr_init = 1'b1;
        k_d       = '0;
        state_d   = RUN;
      end
      RUN: begin
        lfsr_en = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      taps_q  <= '0;
      seed_q  <= '0;
      pre_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      taps_q  <= taps_d;
      seed_q  <= seed_d;
      pre_q   <= pre_d;
      msg_q   <= msg_d;
    end
  end

  // Plaintext selection: preamble, then message bytes, then padding. A message
  // running past OUT_LEN is cut off simply because k never gets there.
  always_comb begin
    k_ext   = {1'b0, k_q};
    pre_end = CMP_W'(pre_q);
    msg_end = pre_end + CMP_W'(msg_q);
    rd_addr = '0;
    ptxt    = PAD_CHAR;
    if (k_ext < pre_end) begin
      ptxt = PREAMBLE_CHAR;
    end else if (k_ext < msg_end) begin
      rd_addr = k_q - K_W'(pre_q);
      ptxt    = data_out;
    end
  end

  // Memory-side outputs; the keystream only covers the low 6 bits.
  always_comb begin
    in_run  = (state_q == RUN);
    wr_en   = in_run;
    raddr   = in_run ? rd_addr : '0;
    waddr   = in_run ? (BASE_ADDR + k_q) : '0;
    data_in = in_run ? (ptxt ^ {2'b00, lfsr_state}) : '0;
    busy    = (state_q == LOAD) || in_run;
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_lfsr_encrypt_stage.sv
module tb_lfsr_encrypt_stage;

  localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  logic       clk = 1'b0;
  logic       init_n;
  logic       start;
  logic [2:0] tap_sel;
  logic [5:0] seed;
  logic [3:0] pre_len;
  logic [6:0] msg_len;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] data_in;
  logic       busy;
  logic       done;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int run_t0    = 0;
  int wr_cnt    = 0;
  int first_wr  = -1;
  int last_wr   = -1;
  int max_raddr = 0;
  int bad_addr  = 0;
  bit prev_done = 1'b0;

  lfsr_encrypt_stage #(.OUT_BASE(64), .OUT_LEN(64)) dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .tap_sel  (tap_sel),
    .seed     (seed),
    .pre_len  (pre_len),
    .msg_len  (msg_len),
    .raddr    (raddr),
    .data_out (data_out),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done)
  );

  assign data_out = mem[raddr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model + scoreboard: writes are taken mid-cycle, while stable.
  always @(negedge clk) begin
    if (init_n === 1'b1 && wr_en === 1'b1) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
      if (waddr < 8'd64 || waddr > 8'd127) bad_addr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got write addr %0d data %02h, required no write", waddr, data_in);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({waddr, data_in} !== mon_exp) begin
          errors++;
          $display("FAIL wr_byte: got addr %0d data %02h, required addr %0d data %02h",
                   waddr, data_in, mon_exp[15:8], mon_exp[7:0]);
        end
      end
      mem[waddr] = data_in;
    end
    if (done === 1'b1 && !prev_done) begin
      checks++;
      if (cyc != run_t0 + 65) begin
        errors++;
        $display("FAIL done_latency: got cycle %0d, required %0d", cyc - run_t0, 65);
      end
      checks++;
      if (wr_cnt != 64 || first_wr != run_t0 + 1 || last_wr != run_t0 + 64) begin
        errors++;
        $display("FAIL run_writes: got count %0d first %0d last %0d, required 64 first 1 last 64",
                 wr_cnt, first_wr - run_t0, last_wr - run_t0);
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic push_expected(input logic [2:0] ts, input logic [5:0] sd,
                               input logic [3:0] pl, input logic [6:0] ml);
    logic [5:0] t;
    logic [5:0] s;
    logic [7:0] pt;
    int p;
    t = TAPS[(ts > 3'd5) ? 0 : int'(ts)];
    s = (sd == 6'd0) ? 6'd1 : sd;
    p = (pl == 4'd0) ? 1 : int'(pl);
    for (int k = 0; k < 64; k++) begin
      if (k < p)                  pt = 8'h5f;
      else if (k < p + int'(ml))  pt = mem[k - p];
      else                        pt = 8'h20;
      exp_q.push_back({8'(64 + k), pt ^ {2'b00, s}});
      s = {s[4:0], ^(s & t)};
    end
  endtask

  task automatic start_run(input logic [2:0] ts, input logic [5:0] sd,
                           input logic [3:0] pl, input logic [6:0] ml, output int t0);
    @(negedge clk);
    tap_sel = ts;
    seed    = sd;
    pre_len = pl;
    msg_len = ml;
    start   = 1'b1;
    push_expected(ts, sd, pl, ml);
    wr_cnt    = 0;
    first_wr  = -1;
    last_wr   = -1;
    max_raddr = 0;
    bad_addr  = 0;
    @(negedge clk);
    t0     = cyc;
    run_t0 = cyc;
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit pulse, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (pulse) start = ((n % 7) == 3) || (n > 55);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    init_n  = 1'b0;
    start   = 1'b0;
    tap_sel = '0;
    seed    = '0;
    pre_len = '0;
    msg_len = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    checks++; if (raddr !== 8'd0)   begin errors++; $display("FAIL rst_raddr: got %02h, required 00", raddr); end
    checks++; if (waddr !== 8'd0)   begin errors++; $display("FAIL rst_waddr: got %02h, required 00", waddr); end
    checks++; if (data_in !== 8'd0) begin errors++; $display("FAIL rst_data_in: got %02h, required 00", data_in); end
    init_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL idle_done: got %b, required 0", done); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en: got %b, required 0", wr_en); end
  endtask

  task automatic test_preamble_only();
    int t0;
    bit ok;
    start_run(3'd0, 6'h01, 4'd7, 7'd0, t0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b, required 1", busy); end
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done, required done"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d pending, required 0", exp_q.size()); end
    checks++; if (mem[64] !== 8'h5e) begin errors++; $display("FAIL basic_m64: got %02h, required 5e", mem[64]); end
    checks++; if (mem[65] !== 8'h5c) begin errors++; $display("FAIL basic_m65: got %02h, required 5c", mem[65]); end
    checks++; if (mem[66] !== 8'h58) begin errors++; $display("FAIL basic_m66: got %02h, required 58", mem[66]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b, required 0", busy); end
  endtask

  task automatic test_decrypt();
    int t0;
    bit ok;
    bit good;
    int found;
    int bad;
    logic [5:0] s;
    logic [5:0] sd;
    logic [7:0] want;
    logic [7:0] txt [4];
    txt = '{8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 4; i++) mem[i] = txt[i];
    start_run(3'd3, 6'h2A, 4'd9, 7'd4, t0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dec_timeout: got no done, required done"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dec_left: got %0d pending, required 0", exp_q.size()); end
    sd = 6'(mem[64] ^ 8'h5f);
    found = -1;
    for (int t = 0; t < 6; t++) begin
      good = 1'b1;
      s = sd;
      for (int k = 0; k < 9; k++) begin
        if ((mem[64 + k] ^ {2'b00, s}) !== 8'h5f) good = 1'b0;
        s = {s[4:0], ^(s & TAPS[t])};
      end
      if (good && found < 0) found = t;
    end
    checks++; if (found != 3) begin errors++; $display("FAIL dec_tap: got %0d, required 3", found); end
    checks++; if (sd !== 6'h2A) begin errors++; $display("FAIL dec_seed: got %02h, required 2a", sd); end
    bad = 0;
    s = sd;
    for (int k = 0; k < 64; k++) begin
      if (k < 9)       want = 8'h5f;
      else if (k < 13) want = txt[k - 9];
      else             want = 8'h20;
      if ((mem[64 + k] ^ {2'b00, s}) !== want) bad++;
      s = {s[4:0], ^(s & TAPS[(found < 0) ? 0 : found])};
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL dec_text: got %0d wrong bytes, required 0", bad); end
  endtask

  task automatic test_seed_zero();
    int t0;
    bit ok;
    int diff;
    logic [7:0] ref_ct [64];
    mem[0] = 8'h61; mem[1] = 8'hC3; mem[2] = 8'h7E;
    start_run(3'd0, 6'h01, 4'd5, 7'd3, t0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sz_ref_timeout: got no done, required done"); end
    for (int i = 0; i < 64; i++) ref_ct[i] = mem[64 + i];
    start_run(3'd7, 6'h00, 4'd5, 7'd3, t0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sz_timeout: got no done, required done"); end
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== ref_ct[i]) diff++;
    checks++; if (diff != 0) begin errors++; $display("FAIL sz_same: got %0d differing bytes, required 0", diff); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sz_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_truncate();
    int t0;
    bit ok;
    for (int i = 0; i < 100; i++) mem[i] = 8'($urandom);
    start_run(3'd5, 6'h1B, 4'd10, 7'd100, t0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tr_timeout: got no done, required done"); end
    checks++; if (wr_cnt != 64) begin errors++; $display("FAIL tr_count: got %0d, required 64", wr_cnt); end
    checks++; if (max_raddr != 53) begin errors++; $display("FAIL tr_last_raddr: got %0d, required 53", max_raddr); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL tr_range: got %0d stray writes, required 0", bad_addr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tr_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int t0;
    bit ok;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h30 + i);
    start_run(3'd2, 6'h15, 4'd4, 7'd6, t0);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (wr_en === 1'b1 && waddr === 8'd84) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rm_reach: got no write at k=20, required one"); end
    init_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0)  begin errors++; $display("FAIL rm_wr_en: got %b, required 0", wr_en); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rm_busy: got %b, required 0", busy); end
    checks++; if (waddr !== 8'd0)  begin errors++; $display("FAIL rm_waddr: got %02h, required 00", waddr); end
    checks++; if (wr_cnt != 20)    begin errors++; $display("FAIL rm_partial: got %0d writes, required 20", wr_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt != 20 || done !== 1'b0) begin
      errors++; $display("FAIL rm_hold: got %0d writes done %b, required 20 writes done 0", wr_cnt, done);
    end
    init_n = 1'b1;
    exp_q.delete();
    start_run(3'd1, 6'h3F, 4'd0, 7'd5, t0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_rerun_timeout: got no done, required done"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_rerun_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit ok;
    int diff;
    logic [7:0] ref_ct [64];
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'hA0 + 3 * i);
    start_run(3'd4, 6'h07, 4'd6, 7'd5, t0);
    wait_done(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no done, required done"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_first_left: got %0d pending, required 0", exp_q.size()); end
    for (int i = 0; i < 64; i++) ref_ct[i] = mem[64 + i];
    @(negedge clk);
    run_t0    = cyc;
    wr_cnt    = 0;
    first_wr  = -1;
    last_wr   = -1;
    push_expected(3'd4, 6'h07, 4'd6, 7'd5);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got busy %b done %b, required busy 1 done 0", busy, done);
    end
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no done, required done"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_second_left: got %0d pending, required 0", exp_q.size()); end
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== ref_ct[i]) diff++;
    checks++; if (diff != 0) begin errors++; $display("FAIL b2b_same: got %0d differing bytes, required 0", diff); end
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1 || wr_cnt != 64) begin
      errors++; $display("FAIL b2b_hold: got done %b writes %0d, required done 1 writes 64", done, wr_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_preamble_only();
    test_decrypt();
    test_seed_zero();
    test_truncate();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
